alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Next-generation parametrised ALU: same opcode encoding as the existing ALU, plus shift-left and set-less-than ops.
- Two-stage pipeline with valid/ready handshakes on both sides; full Z/N/C/V flag set and illegal-opcode error flag.
- Sits between operand sourcing logic (switch/UART front end) and the result consumer; sustains one op per cycle under no backpressure.

Parameters:
- N, 8, operand/result width in bits (N >= 4)
- NSel, 6, opcode width; opcode constants are 6-bit, so NSel must be 6
- SHW, $clog2(N), shift-amount width, derived (localparam)

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  input operation valid
- o_ready  out  1  block can accept input this cycle
- i_alu_A  in  N  operand A
- i_alu_B  in  N  operand B; low SHW bits are the shift amount for shifts
- i_alu_Op  in  NSel  operation code
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result this cycle
- o_alu_Result  out  N  result
- o_flags  out  4  {V,C,N,Z}
- o_err  out  1  illegal opcode for this result

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, s2_valid=0; o_valid=0, o_alu_Result=0, o_flags=0, o_err=0; o_ready=1 on the first cycle after reset.
- Opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010, SLL 000000, SLT 101010 (signed), SLTU 101011 (unsigned).
- Stage 1: registers A, B, Op when the input handshake fires (i_valid & o_ready).
- Stage 2: computes from the stage-1 registers and registers result, flags and err.
- Advance rules: s2_load = s1_valid & (~s2_valid | i_ready); s1_load = ~s1_valid | s2_load; o_ready = s1_load (combinational).
- Latency: 2 cycles from input handshake to o_valid; throughput 1 op/cycle with i_ready held high.
- Backpressure: while o_valid & ~i_ready, o_alu_Result, o_flags and o_err hold stable. Stage 1 holds; o_ready=0 once stage 1 is occupied.
- Input handshake while i_valid=0: no state change. Op, A and B are ignored when not accepted.
- Simultaneous output accept and new stage-1 data: stage 2 reloads in the same edge, with no bubble.
- Arithmetic: ADD/SUB use an N+1-bit internal sum. C = carry-out for ADD and NOT borrow for SUB (C=1 when A>=B unsigned).
- V for ADD: A[N-1]==B[N-1] and R[N-1]!=A[N-1]. V for SUB: A[N-1]!=B[N-1] and R[N-1]!=A[N-1]. Both computed from the new result, never the registered previous one.
- Logic and shift ops: C=0, V=0. Z = (R==0) and N = R[N-1] for all ops.
- Shifts use B[SHW-1:0] only. SRA sign-fills; SRL and SLL zero-fill.
- SLT/SLTU: R = {N-1 zeros, lt}; C=0, V=0.
- Illegal opcode: R=0, flags=0 (Z not set), o_err=1. The result is still delivered through the handshake.
- Reset mid-operation: all in-flight ops are discarded and o_valid drops immediately.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD … OP_SLTU), flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3).
- Sub-module alu_core: purely combinational (A, B, Op) -> (R, flags, err), instantiated in stage 2.
- alu_pipe holds only the pipeline registers and handshake logic.

Test Plan:
- N=8, ADD A=0x7F, B=0x01, i_ready=1 -> after 2 cycles R=0x80, flags V=1 N=1 C=0 Z=0, o_err=0.
- SUB A=0x05, B=0x05 -> R=0x00, Z=1, C=1, V=0. SUB A=0x80, B=0x01 -> R=0x7F, V=1, C=1.
- SRA A=0xF0, B=0x03 -> R=0xFE. SRL same operands -> 0x1E. SLL A=0x81, B=0x09 (amount 1) -> 0x02, N=0. SLT A=0xFF, B=0x01 -> R=0x01; SLTU same operands -> 0x00.
- Backpressure: stream 4 ADDs with i_ready=0 for 3 cycles. Required: o_ready falls after 2 accepts, result holds stable, no op is lost or duplicated, and all 4 results arrive in order.
- Opcode 111111 -> R=0, flags=0000, o_err=1, o_valid handshake completes. The next legal op has o_err=0.
- Assert i_reset_n=0 with both stages full -> o_valid=0 and outputs zero asynchronously. After release, o_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and flag bit positions shared by the ALU pipeline
package alu_pkg;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result, {V,C,N,Z} flags and illegal-opcode error
module alu_core
    import alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int NSel = 6
) (
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [NSel-1:0] op,
    output logic [N-1:0]    r,
    output logic [3:0]      flags,
    output logic            err
);
    localparam int SHW = $clog2(N);
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [SHW-1:0] sh;
    logic           c;
    logic           v;
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        sh   = b[SHW-1:0];
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        err  = 1'b0;
        case (op)
            OP_ADD: begin
                r = sum[N-1:0];
                c = sum[N];
                v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                r = diff[N-1:0];
                c = ~diff[N];
                v = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SRA:  r = $signed(a) >>> sh;
            OP_SRL:  r = a >> sh;
            OP_SLL:  r = a << sh;
            OP_SLT:  r = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: r = {{(N-1){1'b0}}, a < b};
            default: err = 1'b1;
        endcase
        // an illegal op reports all-zero flags, so Z is suppressed too
        flags         = '0;
        flags[FLAG_Z] = ~err & (r == '0);
        flags[FLAG_N] = r[N-1];
        flags[FLAG_C] = c;
        flags[FLAG_V] = v;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline (operand register, then result register)
module alu_pipe
    import alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int NSel = 6
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [N-1:0]    i_alu_A,
    input  logic [N-1:0]    i_alu_B,
    input  logic [NSel-1:0] i_alu_Op,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [N-1:0]    o_alu_Result,
    output logic [3:0]      o_flags,
    output logic            o_err
);
    logic            s1_valid_q, s1_valid_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [NSel-1:0] op_q, op_d;
    logic            s2_valid_q, s2_valid_d;
    logic [N-1:0]    res_q, res_d;
    logic [3:0]      flags_q, flags_d;
    logic            err_q, err_d;
    logic [N-1:0]    core_r;
    logic [3:0]      core_flags;
    logic            core_err;
    logic            s1_load, s2_load, fire;

    alu_core #(.N(N), .NSel(NSel)) u_core (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .r     (core_r),
        .flags (core_flags),
        .err   (core_err)
    );

    // stage 2 drains into the consumer and refills from stage 1 on the same edge
    always_comb begin
        s2_load    = s1_valid_q & (~s2_valid_q | i_ready);
        s1_load    = ~s1_valid_q | s2_load;
        fire       = i_valid & s1_load;
        s1_valid_d = s1_load ? i_valid : s1_valid_q;
        a_d        = fire ? i_alu_A : a_q;
        b_d        = fire ? i_alu_B : b_q;
        op_d       = fire ? i_alu_Op : op_q;
        s2_valid_d = s2_load | (s2_valid_q & ~i_ready);
        res_d      = s2_load ? core_r : res_q;
        flags_d    = s2_load ? core_flags : flags_q;
        err_d      = s2_load ? core_err : err_q;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            flags_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            err_q      <= err_d;
        end
    end

    assign o_ready      = s1_load;
    assign o_valid      = s2_valid_q;
    assign o_alu_Result = res_q;
    assign o_flags      = flags_q;
    assign o_err        = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors plus a scoreboard model checking every delivered result
module tb_alu_pipe;
    localparam int N = 8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] i_a = '0, i_b = '0;
    logic [5:0] i_op = '0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] o_res;
    logic [3:0] o_flags;
    logic       o_err;
    int         total = 0, bad = 0;
    logic [12:0] q[$];
    logic [12:0] held;
    logic        held_v = 1'b0;
    logic [7:0]  ta[8], tb[8];
    logic [5:0]  top[8];

    alu_pipe #(.N(N), .NSel(6)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_alu_A      (i_a),
        .i_alu_B      (i_b),
        .i_alu_Op     (i_op),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_alu_Result (o_res),
        .o_flags      (o_flags),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // {err, V, C, N, Z, result} from plain integer arithmetic
    function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int ua, ub, sa, sb, r, sh;
        logic c, v, e;
        logic [7:0] rr;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); sh = ub % 8;
        c = 0; v = 0; e = 0; r = 0;
        case (op)
            6'b100000: begin r = ua + ub; c = r > 255; v = (sa + sb > 127) || (sa + sb < -128); end
            6'b100010: begin r = ua - ub; c = ua >= ub; v = (sa - sb > 127) || (sa - sb < -128); end
            6'b100100: r = ua & ub;
            6'b100101: r = ua | ub;
            6'b100110: r = ua ^ ub;
            6'b100111: r = ~(ua | ub);
            6'b000011: r = sa >>> sh;
            6'b000010: r = ua >> sh;
            6'b000000: r = ua << sh;
            6'b101010: r = (sa < sb) ? 1 : 0;
            6'b101011: r = (ua < ub) ? 1 : 0;
            default:   e = 1;
        endcase
        rr = r[7:0];
        return {e, v, c, rr[7], (rr == 0) && !e, rr};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            if (o_valid) begin
                if (held_v) chk("hold_stable", {o_err, o_flags, o_res}, held);
                if (i_ready) begin
                    held_v = 1'b0;
                    if (q.size() == 0) chk("extra_result", o_valid, 0);
                    else chk("model", {o_err, o_flags, o_res}, q.pop_front());
                end else begin
                    held = {o_err, o_flags, o_res};
                    held_v = 1'b1;
                end
            end else held_v = 1'b0;
            if (i_valid && o_ready) q.push_back(model(i_a, i_b, i_op));
        end
    end

    task automatic run1(input string name, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                        input logic [7:0] er, input logic [3:0] ef, input logic ee);
        int k, lat;
        @(posedge clk); #1;
        i_ready = 1'b1; i_valid = 1'b1; i_a = a; i_b = b; i_op = op;
        k = 0;
        do begin @(negedge clk); k++; end while (!o_ready && k < 10);
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!o_valid && lat < 10);
        chk({name, "_lat"}, lat, 2);
        chk(name, {o_err, o_flags, o_res}, {ee, ef, er});
    endtask

    task automatic stream(input string name, input int n, input int low);
        int idx, cyc, k;
        logic fire;
        idx = 0; cyc = 0;
        i_ready = (low == 0);
        @(posedge clk); #1;
        i_valid = 1'b1; i_a = ta[0]; i_b = tb[0]; i_op = top[0];
        while (idx < n && cyc < 50) begin
            @(negedge clk);
            if (idx == 2 && cyc < low) chk({name, "_oready_low"}, o_ready, 0);
            fire = o_ready;
            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
            if (cyc >= low) i_ready = 1'b1;
            if (idx < n) begin
                i_a = ta[idx]; i_b = tb[idx]; i_op = top[idx];
            end else i_valid = 1'b0;
        end
        chk({name, "_accepted"}, idx, n);
        if (low == 0) chk({name, "_rate"}, cyc, n);
        k = 0;
        while ((q.size() != 0 || o_valid) && k < 20) begin @(negedge clk); k++; end
        chk({name, "_drained"}, q.size(), 0);
    endtask

    initial begin
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_out", {o_err, o_flags, o_res}, 0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", o_ready, 1);
        run1("add_ovf",  8'h7F, 8'h01, 6'b100000, 8'h80, 4'b1010, 1'b0);
        run1("sub_zero", 8'h05, 8'h05, 6'b100010, 8'h00, 4'b0101, 1'b0);
        run1("sub_ovf",  8'h80, 8'h01, 6'b100010, 8'h7F, 4'b1100, 1'b0);
        run1("sra",      8'hF0, 8'h03, 6'b000011, 8'hFE, 4'b0010, 1'b0);
        run1("srl",      8'hF0, 8'h03, 6'b000010, 8'h1E, 4'b0000, 1'b0);
        run1("sll",      8'h81, 8'h09, 6'b000000, 8'h02, 4'b0000, 1'b0);
        run1("slt",      8'hFF, 8'h01, 6'b101010, 8'h01, 4'b0000, 1'b0);
        run1("sltu",     8'hFF, 8'h01, 6'b101011, 8'h00, 4'b0001, 1'b0);
        run1("illegal",  8'h12, 8'h34, 6'b111111, 8'h00, 4'b0000, 1'b1);
        run1("add_carry",8'hFF, 8'h01, 6'b100000, 8'h00, 4'b0101, 1'b0);
        run1("and",      8'hF0, 8'h3C, 6'b100100, 8'h30, 4'b0000, 1'b0);
        ta = '{8'h10, 8'h7F, 8'hFF, 8'h80, 0, 0, 0, 0};
        tb = '{8'h20, 8'h7F, 8'h02, 8'h80, 0, 0, 0, 0};
        top = '{6'b100000, 6'b100000, 6'b100000, 6'b100000, 0, 0, 0, 0};
        stream("bp", 4, 3);
        ta = '{8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h01, 8'h80, 8'h80, 8'h01};
        tb = '{8'h3C, 8'h3C, 8'h3C, 8'hF0, 8'h07, 8'h07, 8'h07, 8'h02};
        top = '{6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b000000, 6'b000011, 6'b000010, 6'b100010};
        stream("tput", 8, 0);
        @(posedge clk); #1;
        i_ready = 1'b0; i_valid = 1'b1; i_a = 8'h11; i_b = 8'h22; i_op = 6'b100000;
        @(posedge clk); #1;
        i_a = 8'h33; i_op = 6'b100110;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("full_before_rst", {o_valid, o_ready}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_out", {o_err, o_flags, o_res}, 0);
        @(negedge clk); #2;
        rst_n = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", o_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", o_valid, 0);
        end
        run1("after_rst", 8'h40, 8'h40, 6'b100000, 8'h80, 4'b1010, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
